// File: rtl/fp_sgnj_arbiter.sv
// Round-robin arbiter in front of a shared FSGNJ/FSGNJN/FSGNJX datapath
// (single and double precision). One request is accepted per cycle and
// its result is held in a single-entry output register, tagged with the
// source index and requester tag, until the writeback side takes it.
module fp_sgnj_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2,
    parameter int TAG_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       fp_sgnj_arb_i_valid,
    output logic [NUM_REQ-1:0]       fp_sgnj_arb_o_ready,
    input  logic [64*NUM_REQ-1:0]    fp_sgnj_arb_i_data1,
    input  logic [64*NUM_REQ-1:0]    fp_sgnj_arb_i_data2,
    input  logic [2*NUM_REQ-1:0]     fp_sgnj_arb_i_fmt,
    input  logic [3*NUM_REQ-1:0]     fp_sgnj_arb_i_rm,
    input  logic [TAG_W*NUM_REQ-1:0] fp_sgnj_arb_i_tag,
    output logic                     fp_sgnj_arb_o_valid,
    input  logic                     fp_sgnj_arb_i_ready,
    output logic [63:0]              fp_sgnj_arb_o_result,
    output logic [SRC_W-1:0]         fp_sgnj_arb_o_src,
    output logic [TAG_W-1:0]         fp_sgnj_arb_o_tag,
    output logic                     fp_sgnj_arb_o_illegal
);

    typedef enum logic [1:0] {
        FMT_S = 2'd0,
        FMT_D = 2'd1
    } fmt_e;

    typedef enum logic [2:0] {
        RM_SGNJ  = 3'd0,
        RM_SGNJN = 3'd1,
        RM_SGNJX = 3'd2
    } rm_e;

    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] grant;
    logic             grant_found;
    logic [SRC_W:0]   scan_sum;
    logic [SRC_W-1:0] scan_idx;
    logic             can_accept;
    logic             accept;

    logic [63:0]      sel_d1;
    logic [63:0]      sel_d2;
    logic [1:0]       sel_fmt;
    logic [2:0]       sel_rm;
    logic [TAG_W-1:0] sel_tag;

    logic             sign_a;
    logic             sign_b;
    logic             sign_r;
    logic             rm_bad;
    logic [63:0]      res;
    logic             res_illegal;

    // A full output register can only take a new entry if it drains this cycle.
    assign can_accept = !fp_sgnj_arb_o_valid | fp_sgnj_arb_i_ready;

    // Round-robin scan: first valid requester at or after ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        grant       = '0;
        grant_found = 1'b0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr} + (SRC_W+1)'(k);
            if (scan_sum >= (SRC_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
            scan_idx = scan_sum[SRC_W-1:0];
            if (!grant_found && fp_sgnj_arb_i_valid[scan_idx]) begin
                grant       = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    // One-hot accept toward the granted requester; held low during reset.
    always_comb begin
        fp_sgnj_arb_o_ready = '0;
        if (rst_n && can_accept && grant_found)
            fp_sgnj_arb_o_ready[grant] = 1'b1;
    end

    assign accept = |fp_sgnj_arb_o_ready;

    // Operand fields of the granted requester.
    assign sel_d1  = fp_sgnj_arb_i_data1[64*grant +: 64];
    assign sel_d2  = fp_sgnj_arb_i_data2[64*grant +: 64];
    assign sel_fmt = fp_sgnj_arb_i_fmt[2*grant +: 2];
    assign sel_rm  = fp_sgnj_arb_i_rm[3*grant +: 3];
    assign sel_tag = fp_sgnj_arb_i_tag[TAG_W*grant +: TAG_W];

    // Sign-injection datapath; unsupported rm forces sign 0, bad fmt zeroes all.
    always_comb begin
        sign_a      = (sel_fmt == FMT_D) ? sel_d1[63] : sel_d1[31];
        sign_b      = (sel_fmt == FMT_D) ? sel_d2[63] : sel_d2[31];
        sign_r      = 1'b0;
        rm_bad      = 1'b0;
        res         = '0;
        res_illegal = 1'b0;
        case (sel_rm)
            RM_SGNJ:  sign_r = sign_b;
            RM_SGNJN: sign_r = ~sign_b;
            RM_SGNJX: sign_r = sign_a ^ sign_b;
            default:  rm_bad = 1'b1;
        endcase
        case (sel_fmt)
            FMT_S: begin
                res         = {32'b0, sign_r, sel_d1[30:0]};
                res_illegal = rm_bad;
            end
            FMT_D: begin
                res         = {sign_r, sel_d1[62:0]};
                res_illegal = rm_bad;
            end
            default: begin
                res         = '0;
                res_illegal = 1'b1;
            end
        endcase
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the result payload is reset too, so outputs read 0 straight out of reset.
        if (!rst_n) begin
            fp_sgnj_arb_o_valid   <= 1'b0;
            fp_sgnj_arb_o_result  <= '0;
            fp_sgnj_arb_o_src     <= '0;
            fp_sgnj_arb_o_tag     <= '0;
            fp_sgnj_arb_o_illegal <= 1'b0;
            ptr                   <= '0;
        end else if (accept) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            fp_sgnj_arb_o_valid   <= 1'b1;
            fp_sgnj_arb_o_result  <= res;
            fp_sgnj_arb_o_src     <= grant;
            fp_sgnj_arb_o_tag     <= sel_tag;
            fp_sgnj_arb_o_illegal <= res_illegal;
            ptr                   <= (grant == SRC_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        end else if (fp_sgnj_arb_i_ready) begin
            fp_sgnj_arb_o_valid   <= 1'b0;
        end
    end

endmodule

// File: doc/fp_sgnj_arbiter.md
# fp_sgnj_arbiter

Round-robin arbiter and sequencer that shares one floating-point sign-injection datapath (FSGNJ/FSGNJN/FSGNJX, single and double precision) between NUM_REQ requesters in the EX stage float cluster. It accepts at most one operation per cycle over valid/ready handshakes, computes the sign-injected result, and holds it in a single-entry output register tagged with source index and requester tag until the writeback side takes it.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥2.
- SRC_W, 2: width of the source index; must equal ceil(log2(NUM_REQ)).
- TAG_W, 5: width of the per-request tag, e.g. a destination register id.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fp_sgnj_arb_i_valid  in  NUM_REQ  per-requester request valid.
- fp_sgnj_arb_o_ready  out  NUM_REQ  per-requester accept; at most one bit is high.
- fp_sgnj_arb_i_data1  in  64*NUM_REQ  operand 1; requester i occupies bits [64i+63:64i].
- fp_sgnj_arb_i_data2  in  64*NUM_REQ  operand 2, packed the same way.
- fp_sgnj_arb_i_fmt  in  2*NUM_REQ  format: 0 = single, 1 = double, 2/3 = unsupported.
- fp_sgnj_arb_i_rm  in  3*NUM_REQ  function select: 0 = SGNJ, 1 = SGNJN, 2 = SGNJX.
- fp_sgnj_arb_i_tag  in  TAG_W*NUM_REQ  opaque tag, returned with the result.
- fp_sgnj_arb_o_valid  out  1  result register holds a valid result.
- fp_sgnj_arb_i_ready  in  1  consumer accepts the result.
- fp_sgnj_arb_o_result  out  64  sign-injected result.
- fp_sgnj_arb_o_src  out  SRC_W  index of the requester that produced the result.
- fp_sgnj_arb_o_tag  out  TAG_W  tag of that request.
- fp_sgnj_arb_o_illegal  out  1  fmt was 2/3 or rm was 3..7 for this result.

## Operation
- can_accept = !o_valid | i_ready, where o_valid is the registered output valid.
- Arbitration: scan requesters starting at ptr, wrapping modulo NUM_REQ. The first index with i_valid set is the grant g.
- o_ready[i] = can_accept & (i == g) & i_valid[g]. It is combinational from i_valid and i_ready.
- Accept happens when o_ready[g] is high. On accept:
  - latch the result, src = g, tag[g] and the illegal flag;
  - set o_valid = 1;
  - set ptr = (g + 1) mod NUM_REQ.
- ptr does not change in a cycle with no accept.
- Datapath, from requester g's operands:
  - fmt 0: result[30:0] = data1[30:0]; result[63:32] = 0. Sign bit 31 is data2[31] for rm 0, ~data2[31] for rm 1, data1[31]^data2[31] for rm 2.
  - fmt 1: result[62:0] = data1[62:0]. Sign bit 63 follows the same rules using bit 63.
  - fmt 0/1 with rm 3..7: sign bit = 0, magnitude copied as above, illegal = 1.
  - fmt 2/3: result = 0, illegal = 1.
- Output transfer completes when o_valid & i_ready. If no accept occurs in that same cycle, o_valid goes to 0.
- While o_valid & !i_ready: result, src, tag and illegal are held stable, and all o_ready bits are 0.

## Timing
- Reset (rst_n low, asynchronous): o_valid = 0, o_result = 0, o_src = 0, o_tag = 0, o_illegal = 0, ptr = 0. o_ready reads 0 during reset.
- Latency: a request accepted on edge N is visible on the outputs after edge N. A requester's request cannot be accepted before the cycle it asserts valid.
- Throughput: 1 result per cycle while i_ready stays high, with no bubbles.
- Simultaneous output drain and accept in one cycle: the new result replaces the old one and o_valid stays 1.
- A requester may drop i_valid without being accepted; no state is left behind.
- If rst_n is asserted mid-stall, the held result is discarded. The first grant after reset goes to the lowest valid index at or after 0.
- Fairness: with all requesters continuously valid and i_ready = 1, grants rotate 0,1,…,NUM_REQ-1,0. Every valid requester is granted within NUM_REQ accepts.

## Test plan
- Reset: drive rst_n low mid-cycle with o_valid = 1 -> o_valid, o_result, o_src, o_tag and o_illegal are 0 immediately; ptr = 0; the next grant is requester 0 when all are valid.
- Single-precision functions: requester 2 sends data1 = 0x3F800000, data2 = 0xBF800000, fmt 0, with rm 0/1/2 in turn -> results 0xBF800000, 0x3F800000, 0xBF800000, each with src = 2, one cycle after accept.
- Double precision and illegal: data1 = 0xC000000000000000, data2 = 0x8000000000000000, fmt 1, rm 2 -> result 0x4000000000000000, illegal = 0. The same operands with fmt 2 -> result 0, illegal = 1. With fmt 1, rm 5 -> result 0x4000000000000000, illegal = 1.
- Round-robin: all 4 requesters valid with distinct tags and i_ready = 1 for 8 cycles -> src sequence 0,1,2,3,0,1,2,3 with matching tags; exactly one o_ready bit high per cycle.
- Backpressure: i_ready = 0 for 3 cycles while o_valid = 1 -> outputs stable, all o_ready = 0, ptr unchanged. Then i_ready = 1 -> the result drains and the next requester is accepted in that same cycle, so o_valid stays 1.
- Sparse requests: only requester 3 valid, then only requester 1 -> grant 3 then 1, ptr becomes 0 then 2; o_valid drops after drain when no request is present.
